// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the ALU share arbiter.
// Includes the ALU control codes and the arbiter FSM states.
package alu_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 4;

   typedef enum logic [3:0] {
      AND = 4'b0000,
      OR  = 4'b0001,
      ADD = 4'b0010,
      SUB = 4'b0110,
      SLT = 4'b0111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin grant.
// On a tie, the requester that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant    = 2'b00;
      grant_id = 1'b0;
      case (valid)
         2'b01: begin
            grant    = 2'b01;
            grant_id = 1'b0;
         end
         2'b10: begin
            grant    = 2'b10;
            grant_id = 1'b1;
         end
         2'b11: begin
            if (last_grant) begin
               grant    = 2'b01;
               grant_id = 1'b0;
            end else begin
               grant    = 2'b10;
               grant_id = 1'b1;
            end
         end
         default: begin
            grant    = 2'b00;
            grant_id = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_ILLEGAL_CHK_EN to flag unsupported control codes on rsp_err_o.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_src1_i,
   input  logic [DATA_W-1:0] req0_src2_i,
   input  logic [CTRL_W-1:0] req0_ctrl_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_src1_i,
   input  logic [DATA_W-1:0] req1_src2_i,
   input  logic [CTRL_W-1:0] req1_ctrl_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_id_o,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic              rsp_zero_o,
   output logic              rsp_err_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q;
   logic [DATA_W-1:0] src1_q, src2_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              id_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              rsp_id_q;

   logic [1:0]        grant;
   logic              grant_id;
   logic              accept_en;
   logic              accept;
   logic [DATA_W-1:0] sel_src1, sel_src2;
   logic [CTRL_W-1:0] sel_ctrl;

   rr_arb2 u_rr_arb2 (
      .valid      ({req1_valid_i, req0_valid_i}),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_id   (grant_id)
   );

   // A new op may be taken when idle, or when the held response drains this cycle.
   assign accept_en = !rst_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
   assign accept    = accept_en && (grant != 2'b00);

   assign req0_ready_o = accept_en && grant[0];
   assign req1_ready_o = accept_en && grant[1];

   assign sel_src1 = grant_id ? req1_src1_i : req0_src1_i;
   assign sel_src2 = grant_id ? req1_src2_i : req0_src2_i;
   assign sel_ctrl = grant_id ? req1_ctrl_i : req0_ctrl_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = accept ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         src1_q       <= '0;
         src2_q       <= '0;
         ctrl_q       <= '0;
         id_q         <= 1'b0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            src1_q       <= sel_src1;
            src2_q       <= sel_src2;
            ctrl_q       <= sel_ctrl;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
         end
         // The ALU sees the latched operands during EXEC; capture its answer then.
         if (state_q == EXEC) begin
            result_q <= alu_result_i;
            zero_q   <= alu_zero_i;
            rsp_id_q <= id_q;
         end
      end
   end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
   logic err_pend_q;
   logic err_q;
   logic sel_legal;

   assign sel_legal = (sel_ctrl == CTRL_W'(AND)) || (sel_ctrl == CTRL_W'(OR)) ||
                      (sel_ctrl == CTRL_W'(ADD)) || (sel_ctrl == CTRL_W'(SUB)) ||
                      (sel_ctrl == CTRL_W'(SLT));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) err_pend_q <= !sel_legal;
         if (state_q == EXEC) err_q <= err_pend_q;
      end
   end

   assign rsp_err_o = err_q;
`else
   assign rsp_err_o = 1'b0;
`endif

   assign rsp_valid_o  = (state_q == RESP);
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = result_q;
   assign rsp_zero_o   = zero_q;
   assign alu_src1_o   = src1_q;
   assign alu_src2_o   = src2_q;
   assign alu_ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
// Honours ALU_ARB_ILLEGAL_CHK_EN when predicting rsp_err_o.
module tb_alu_share_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req0_ready_o;
   logic [31:0] req0_src1_i, req0_src2_i;
   logic [3:0]  req0_ctrl_i;
   logic        req1_valid_i, req1_ready_o;
   logic [31:0] req1_src1_i, req1_src2_i;
   logic [3:0]  req1_ctrl_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_err_o;
   logic [31:0] rsp_result_o;
   logic [31:0] alu_src1_o, alu_src2_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_result_i;
   logic        alu_zero_i;

   int checks   = 0;
   int failures = 0;
   logic exp_err;

   always #5 clk_i = ~clk_i;

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_src1_i  (req0_src1_i),
      .req0_src2_i  (req0_src2_i),
      .req0_ctrl_i  (req0_ctrl_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_src1_i  (req1_src1_i),
      .req1_src2_i  (req1_src2_i),
      .req1_ctrl_i  (req1_ctrl_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_result_o (rsp_result_o),
      .rsp_zero_o   (rsp_zero_o),
      .rsp_err_o    (rsp_err_o),
      .alu_src1_o   (alu_src1_o),
      .alu_src2_o   (alu_src2_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_result_i (alu_result_i),
      .alu_zero_i   (alu_zero_i)
   );

   // External ALU: unsupported codes yield 0.
   always_comb begin
      alu_result_i = 32'd0;
      case (alu_ctrl_o)
         4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
         4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
         4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
         4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
         4'b0111: alu_result_i = ($signed(alu_src1_o) < $signed(alu_src2_o)) ? 32'd1 : 32'd0;
         default: alu_result_i = 32'd0;
      endcase
   end
   assign alu_zero_i = (alu_result_i == 32'd0);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic port, input logic v, input logic [3:0] ctrl,
                                input logic [31:0] a, input logic [31:0] b);
      if (port == 1'b0) begin
         req0_valid_i = v; req0_ctrl_i = ctrl; req0_src1_i = a; req0_src2_i = b;
      end else begin
         req1_valid_i = v; req1_ctrl_i = ctrl; req1_src1_i = a; req1_src2_i = b;
      end
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      rsp_ready_i = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
      applyStimulus(1'b1, 1'b1, 4'b0010, 32'd2, 32'd2);

      // Reset held two cycles with both requesters valid
      step();
      step();
      checkOutput("rst_ready0", 32'(req0_ready_o), 32'd0);
      checkOutput("rst_ready1", 32'(req1_ready_o), 32'd0);
      checkOutput("rst_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_result", rsp_result_o, 32'd0);
      checkOutput("rst_id_zero_err", {29'd0, rsp_id_o, rsp_zero_o, rsp_err_o}, 32'd0);
      checkOutput("rst_alu_src1", alu_src1_o, 32'd0);
      checkOutput("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);

      // Contention: req0 SUB 9,9 and req1 OR F0,0F
      applyStimulus(1'b0, 1'b1, 4'b0110, 32'd9, 32'd9);
      applyStimulus(1'b1, 1'b1, 4'b0001, 32'hF0, 32'h0F);
      rst_i = 1'b0;
      rsp_ready_i = 1'b1;
      #1;
      checkOutput("tie_ready0", 32'(req0_ready_o), 32'd1);
      checkOutput("tie_ready1", 32'(req1_ready_o), 32'd0);
      step();
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      checkOutput("exec_ready1", 32'(req1_ready_o), 32'd0);
      checkOutput("exec_valid", 32'(rsp_valid_o), 32'd0);
      step();
      checkOutput("c1_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("c1_result", rsp_result_o, 32'd0);
      checkOutput("c1_zero", 32'(rsp_zero_o), 32'd1);
      checkOutput("c1_id", 32'(rsp_id_o), 32'd0);
      checkOutput("b2b_ready1", 32'(req1_ready_o), 32'd1);
      step();
      applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
      checkOutput("c2_exec_valid", 32'(rsp_valid_o), 32'd0);
      step();
      checkOutput("c2_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("c2_result", rsp_result_o, 32'hFF);
      checkOutput("c2_zero", 32'(rsp_zero_o), 32'd0);
      checkOutput("c2_id", 32'(rsp_id_o), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
      applyStimulus(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1);
      checkOutput("tie2_ready0", 32'(req0_ready_o), 32'd1);
      checkOutput("tie2_ready1", 32'(req1_ready_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
      step();
      rsp_ready_i = 1'b0;
      checkOutput("drain_idle", 32'(rsp_valid_o), 32'd0);

      // Single op: req0 ADD 5,7
      applyStimulus(1'b0, 1'b1, 4'b0010, 32'd5, 32'd7);
      checkOutput("s_ready0", 32'(req0_ready_o), 32'd1);
      checkOutput("s_ready1", 32'(req1_ready_o), 32'd0);
      step();
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      checkOutput("s_n1_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("s_alu_src1", alu_src1_o, 32'd5);
      checkOutput("s_alu_ctrl", 32'(alu_ctrl_o), 32'd2);
      step();
      checkOutput("s_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("s_result", rsp_result_o, 32'd12);
      checkOutput("s_zero", 32'(rsp_zero_o), 32'd0);
      checkOutput("s_id", 32'(rsp_id_o), 32'd0);

      // Backpressure with req1 ADD 100,23 waiting
      applyStimulus(1'b1, 1'b1, 4'b0010, 32'd100, 32'd23);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_ready1", 32'(req1_ready_o), 32'd0);
         checkOutput("bp_valid", 32'(rsp_valid_o), 32'd1);
         checkOutput("bp_result", rsp_result_o, 32'd12);
         checkOutput("bp_id", 32'(rsp_id_o), 32'd0);
         checkOutput("bp_alu_hold", alu_src2_o, 32'd7);
         step();
      end
      rsp_ready_i = 1'b1;
      #1;
      checkOutput("bp_release_ready1", 32'(req1_ready_o), 32'd1);
      step();
      applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
      rsp_ready_i = 1'b0;
      checkOutput("bp_exec_valid", 32'(rsp_valid_o), 32'd0);
      step();
      checkOutput("bp2_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("bp2_result", rsp_result_o, 32'd123);
      checkOutput("bp2_id", 32'(rsp_id_o), 32'd1);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;

      // Reset during EXEC discards req1 SLT 3,8
      applyStimulus(1'b1, 1'b1, 4'b0111, 32'd3, 32'd8);
      checkOutput("mr_ready1", 32'(req1_ready_o), 32'd1);
      step();
      applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      checkOutput("mr_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("mr_result", rsp_result_o, 32'd0);
      checkOutput("mr_alu_src1", alu_src1_o, 32'd0);
      step();
      checkOutput("mr_valid2", 32'(rsp_valid_o), 32'd0);
      applyStimulus(1'b0, 1'b1, 4'b0000, 32'hC, 32'hA);
      step();
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      step();
      checkOutput("mr_next_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("mr_next_result", rsp_result_o, 32'h8);
      checkOutput("mr_next_id", 32'(rsp_id_o), 32'd0);
      checkOutput("legal_err", 32'(rsp_err_o), 32'd0);
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;

      // Illegal ctrl 1111 on req0
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      applyStimulus(1'b0, 1'b1, 4'b1111, 32'd1, 32'd2);
      step();
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      checkOutput("ill_alu_ctrl", 32'(alu_ctrl_o), 32'hF);
      step();
      checkOutput("ill_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("ill_result", rsp_result_o, 32'd0);
      checkOutput("ill_zero", 32'(rsp_zero_o), 32'd1);
      checkOutput("ill_err", 32'(rsp_err_o), 32'(exp_err));
      rsp_ready_i = 1'b1;
      step();
      checkOutput("end_idle", 32'(rsp_valid_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
